// File: rtl/pio_regs_pkg.sv
// Register map of the push-button PIO slave and the servicer state encoding.
package pio_regs_pkg;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  typedef enum logic [3:0] {
    INIT_MASK,
    IDLE,
    CFG_WR,
    RD_EDGE,
    RD_EDGE_W,
    CLR,
    RD_LVL,
    RD_LVL_W,
    PUSH
  } svc_state_t;

endpackage

// File: rtl/button_irq_servicer.sv
// Avalon-MM master that services the push-button PIO interrupt in hardware and
// emits one {edges, level} event per real interrupt on a valid/ready stream.
module button_irq_servicer
  import pio_regs_pkg::*;
#(
  parameter int unsigned          WIDTH      = 4,
  parameter logic [WIDTH-1:0]     MASK_RESET = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_irq,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_load,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             busy
);

  svc_state_t       state, state_nxt;
  logic [WIDTH-1:0] mask_q;
  logic             cfg_pend;
  logic [WIDTH-1:0] edges_q;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] wr_val;

  logic unused_rd_hi;
  assign unused_rd_hi = ^avm_readdata[31:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_MASK;
      mask_q    <= MASK_RESET;
      cfg_pend  <= 1'b0;
      edges_q   <= '0;
      level_q   <= '0;
      evt_valid <= 1'b0;
      evt_edges <= '0;
      evt_level <= '0;
    end else begin
      state <= state_nxt;

      // A load landing in the CFG_WR cycle keeps the pend so the newer mask is written too.
      if (cfg_load) begin
        mask_q   <= cfg_mask;
        cfg_pend <= 1'b1;
      end else if (state == CFG_WR) begin
        cfg_pend <= 1'b0;
      end

      if (state == RD_EDGE_W) edges_q <= avm_readdata[WIDTH-1:0] & mask_q;
      if (state == RD_LVL_W)  level_q <= avm_readdata[WIDTH-1:0];

      if (state == PUSH) begin
        evt_valid <= 1'b1;
        evt_edges <= edges_q;
        evt_level <= level_q;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT_MASK: state_nxt = IDLE;
      IDLE: begin
        if (cfg_pend || cfg_load)       state_nxt = CFG_WR;
        else if (avm_irq && !evt_valid) state_nxt = RD_EDGE;
      end
      CFG_WR:    state_nxt = IDLE;
      RD_EDGE:   state_nxt = RD_EDGE_W;
      RD_EDGE_W: state_nxt = CLR;
      CLR:       state_nxt = RD_LVL;
      RD_LVL:    state_nxt = RD_LVL_W;
      RD_LVL_W:  state_nxt = (edges_q != '0) ? PUSH : IDLE;
      PUSH:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Bus is held idle while reset is asserted, so the reset-time mask write is a
  // single strobe in the first cycle after release however long reset is held.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = PIO_DATA;
    wr_val         = '0;
    if (!reset) begin
      unique case (state)
        INIT_MASK: begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = PIO_MASK;
          wr_val         = MASK_RESET;
        end
        CFG_WR: begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = PIO_MASK;
          wr_val         = mask_q;
        end
        RD_EDGE: begin
          avm_chipselect = 1'b1;
          avm_address    = PIO_EDGE;
        end
        CLR: begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = PIO_EDGE;
        end
        RD_LVL: begin
          avm_chipselect = 1'b1;
          avm_address    = PIO_DATA;
        end
        default: ;
      endcase
    end
  end

  assign avm_writedata = 32'(wr_val);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_button_irq_servicer.sv
// Directed bench: behavioural PIO slave plus hand-computed bus sequences and events.
module tb_button_irq_servicer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h5A5A5A5A;
  logic        avm_irq;
  logic [3:0]  cfg_mask;
  logic        cfg_load;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_edges;
  logic [3:0]  evt_level;
  logic        busy;

  logic [3:0]  edge_cap = '0;
  logic [3:0]  pmask    = '0;
  logic [3:0]  lvl      = '0;
  logic [3:0]  inj      = '0;
  logic        spur     = 1'b0;

  int total = 0;
  int bad   = 0;

  button_irq_servicer #(.WIDTH(4), .MASK_RESET(4'hF)) dut (
    .clk            (clk),
    .reset          (reset),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_irq        (avm_irq),
    .cfg_mask       (cfg_mask),
    .cfg_load       (cfg_load),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_edges      (evt_edges),
    .evt_level      (evt_level),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // PIO slave: read data one cycle after strobe, garbage in the upper bits.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        2'd0:    avm_readdata <= {28'hC0FFEE0, lvl};
        2'd2:    avm_readdata <= {28'hC0FFEE0, pmask};
        2'd3:    avm_readdata <= {28'hC0FFEE0, (spur ? 4'b0000 : edge_cap)};
        default: avm_readdata <= 32'h5A5A5A5A;
      endcase
    end else begin
      avm_readdata <= 32'h5A5A5A5A;
    end
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pmask <= avm_writedata[3:0];
    edge_cap <= ((avm_chipselect && !avm_write_n && avm_address == 2'd3) ? 4'b0000 : edge_cap) | inj;
  end

  assign avm_irq = |(edge_cap & pmask);

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
    chk(tag, {28'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
             {28'd0, cs, wn, a, wd});
  endtask

  // One-cycle edge injection; returns at the first negedge with irq visible.
  task automatic press(input logic [3:0] e);
    inj = e;
    tick;
    inj = 4'b0000;
  endtask

  // Called with the DUT in IDLE and irq high; walks the full service sequence.
  task automatic expect_service(input logic [3:0] e, input logic [3:0] l, input bit push);
    tick; chk_bus("rd_edge",   1'b1, 1'b1, 2'd3, 32'd0);
    tick; chk_bus("rd_edge_w", 1'b0, 1'b1, 2'd0, 32'd0);
    tick; chk_bus("clr",       1'b1, 1'b0, 2'd3, 32'd0);
    tick; chk_bus("rd_lvl",    1'b1, 1'b1, 2'd0, 32'd0);
    tick; chk_bus("rd_lvl_w",  1'b0, 1'b1, 2'd0, 32'd0);
    tick;
    if (push) begin
      chk("push_busy",  busy, 1);
      chk("push_valid", evt_valid, 0);
      tick;
      chk("evt_valid", evt_valid, 1);
      chk("evt_edges", evt_edges, e);
      chk("evt_level", evt_level, l);
      chk("evt_busy",  busy, 0);
    end else begin
      chk("spur_busy",  busy, 0);
      chk("spur_valid", evt_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_mask = 4'b0000; cfg_load = 1'b0; evt_ready = 1'b1;

    // reset and the single mask write after release
    tick;
    chk_bus("rst_bus", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("rst_busy",  busy, 1);
    chk("rst_valid", evt_valid, 0);
    chk("rst_edges", evt_edges, 0);
    chk("rst_level", evt_level, 0);
    tick;
    reset = 1'b0;
    #1 chk_bus("init_mask", 1'b1, 1'b0, 2'd2, 32'h0000000F);
    tick; chk_bus("idle_bus0", 1'b0, 1'b1, 2'd0, 32'd0); chk("idle_busy0", busy, 0);
    tick; chk_bus("idle_bus1", 1'b0, 1'b1, 2'd0, 32'd0); chk("idle_busy1", busy, 0);

    // button 1 press, consumer ready
    lvl = 4'b0010;
    press(4'b0010);
    chk("pre_busy", busy, 0);
    expect_service(4'b0010, 4'b0010, 1'b1);
    tick; chk("valid_drop", evt_valid, 0);

    // spurious irq: edge read returns 0
    spur = 1'b1; lvl = 4'b0000;
    press(4'b0001);
    expect_service(4'b0000, 4'b0000, 1'b0);
    tick; chk("spur_valid2", evt_valid, 0); chk("spur_irq_cleared", avm_irq, 0);
    spur = 1'b0;

    // backpressure: second irq held off while event pending
    evt_ready = 1'b0; lvl = 4'b0001;
    press(4'b0001);
    expect_service(4'b0001, 4'b0001, 1'b1);
    lvl = 4'b1000;
    press(4'b0100);
    for (int i = 0; i < 4; i++) begin
      chk_bus("bp_bus", 1'b0, 1'b1, 2'd0, 32'd0);
      chk("bp_valid", evt_valid, 1);
      chk("bp_edges", evt_edges, 4'b0001);
      chk("bp_level", evt_level, 4'b0001);
      chk("bp_busy",  busy, 0);
      tick;
    end
    evt_ready = 1'b1;
    tick; chk("bp_accept", evt_valid, 0); chk("bp_idle", busy, 0);
    expect_service(4'b0100, 4'b1000, 1'b1);
    tick; chk("bp_drop", evt_valid, 0);

    // cfg_load coincident with irq: mask write first, then masked capture
    lvl = 4'b0110;
    press(4'b1110);
    cfg_mask = 4'b0011; cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    chk_bus("cfg_wr", 1'b1, 1'b0, 2'd2, 32'h00000003);
    chk("cfg_busy", busy, 1);
    tick; chk("cfg_idle", busy, 0);
    expect_service(4'b0010, 4'b0110, 1'b1);
    tick; chk("cfg_drop", evt_valid, 0);

    // reset asserted in CLR abandons the service
    lvl = 4'b0001;
    press(4'b0001);
    tick; chk_bus("r_rd_edge", 1'b1, 1'b1, 2'd3, 32'd0);
    tick;
    tick; chk_bus("r_clr", 1'b1, 1'b0, 2'd3, 32'd0);
    reset = 1'b1;
    #1 chk_bus("r_gate", 1'b0, 1'b1, 2'd0, 32'd0);
    tick;
    chk_bus("r_bus", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("r_valid", evt_valid, 0);
    chk("r_busy",  busy, 1);
    reset = 1'b0;
    #1 chk_bus("r_init_mask", 1'b1, 1'b0, 2'd2, 32'h0000000F);
    tick; chk("r_idle", busy, 0);
    expect_service(4'b0001, 4'b0001, 1'b1);
    tick; chk("r_drop", evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
